// File: rtl/common_pkg.sv
// common: shared fixed-width word types.
package common;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
endpackage

// File: rtl/pipes_pkg.sv
// pipes: pipeline handshake types, fetch FSM states and fetch reset vector.
package pipes;
  import common::*;
  typedef enum logic {INSTR_CONTINUE, INSTR_MAINTAIN} instr_FETCH_t;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, VALID} fetch_state_t;
  localparam u64 RESET_PC = 64'h8000_0000;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch FSM with redirect draining; FETCH_CTRL_PERF_EN adds fetch/stall counters.
module fetch_ctrl
  import common::*, pipes::*;
(
  input  logic         clk,
  input  logic         resetn,
  output logic         ireq_valid,
  output u64           ireq_addr,
  input  logic         iresp_data_ok,
  input  u32           iresp_data,
  input  logic         stall_F,
  input  logic         redirect_valid,
  input  u64           redirect_pc,
  output u64           pc,
  output u32           raw_instr,
  output logic         ivalid,
  output instr_FETCH_t instr_FETCH,
`ifdef FETCH_CTRL_PERF_EN
  output u64           fetch_cnt,
  output u64           stall_cnt,
`endif
  output logic         Iwait
);
  fetch_state_t state_q, state_d;
  u64 pc_q, pc_d, tgt_q, tgt_d;
  u32 instr_q, instr_d;
  u64 redir_tgt;
  assign redir_tgt   = redirect_pc & ~64'd3;
  assign ireq_valid  = (state_q == REQ) || (state_q == DRAIN);
  assign ireq_addr   = pc_q;
  assign pc          = pc_q;
  assign raw_instr   = instr_q;
  assign ivalid      = state_q == VALID;
  assign Iwait       = ireq_valid & ~iresp_data_ok;
  // state, PC, saved redirect target and latched instruction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
    end
  end
  // next state; a redirect while a request is outstanding waits in DRAIN for the stale response
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    instr_d     = instr_q;
    instr_FETCH = INSTR_CONTINUE;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        pc_d    = redirect_valid ? redir_tgt : pc_q;
      end
      REQ: begin
        if (iresp_data_ok) begin
          state_d = redirect_valid ? REQ : VALID;
          pc_d    = redirect_valid ? redir_tgt : pc_q;
          instr_d = redirect_valid ? instr_q : iresp_data;
        end else if (redirect_valid) begin
          state_d = DRAIN;
          tgt_d   = redir_tgt;
        end
      end
      DRAIN: begin
        tgt_d = redirect_valid ? redir_tgt : tgt_q;
        if (iresp_data_ok) begin
          state_d = REQ;
          pc_d    = tgt_d;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          state_d = REQ;
          pc_d    = redir_tgt;
        end else if (stall_F) begin
          instr_FETCH = INSTR_MAINTAIN;
        end else begin
          state_d = REQ;
          pc_d    = pc_q + 64'd4;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef FETCH_CTRL_PERF_EN
  // delivered-instruction and bus-wait counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + {63'd0, (state_q == VALID) && !stall_F};
      stall_cnt <= stall_cnt + {63'd0, Iwait};
    end
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random checks of fetch_ctrl against a transaction-level model.
module tb_fetch_ctrl;
  import pipes::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ireq_valid, ivalid, Iwait;
  logic [63:0] ireq_addr, pc;
  logic [31:0] raw_instr;
  instr_FETCH_t instr_FETCH;
  logic iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic stall_F = 1'b0;
  logic redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  int checks = 0;
  int failures = 0;
  bit m_started, m_have, m_discard;
  logic [63:0] m_pc, m_tgt;
  logic [31:0] m_word;
`ifdef FETCH_CTRL_PERF_EN
  logic [63:0] fetch_cnt, stall_cnt, m_fc, m_sc;
`endif

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .resetn(resetn), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .stall_F(stall_F),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc),
    .raw_instr(raw_instr), .ivalid(ivalid), .instr_FETCH(instr_FETCH),
`ifdef FETCH_CTRL_PERF_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
    .Iwait(Iwait)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_have    = 0;
    m_discard = 0;
    m_pc      = 64'h8000_0000;
    m_tgt     = '0;
    m_word    = '0;
`ifdef FETCH_CTRL_PERF_EN
    m_fc = '0;
    m_sc = '0;
`endif
  endtask

  task automatic model_step();
    logic [63:0] tgt;
    tgt = redirect_pc & ~64'd3;
`ifdef FETCH_CTRL_PERF_EN
    if (m_have && !stall_F) m_fc++;
    if (m_started && !m_have && !iresp_data_ok) m_sc++;
`endif
    if (!m_started) begin
      m_started = 1;
      if (redirect_valid) m_pc = tgt;
    end else if (m_have) begin
      if (redirect_valid) begin
        m_pc = tgt;
        m_have = 0;
      end else if (!stall_F) begin
        m_pc = m_pc + 64'd4;
        m_have = 0;
      end
    end else if (m_discard) begin
      if (redirect_valid) m_tgt = tgt;
      if (iresp_data_ok) begin
        m_pc = m_tgt;
        m_discard = 0;
      end
    end else if (iresp_data_ok) begin
      if (redirect_valid) m_pc = tgt;
      else begin
        m_word = iresp_data;
        m_have = 1;
      end
    end else if (redirect_valid) begin
      m_discard = 1;
      m_tgt = tgt;
    end
  endtask

  task automatic compare_all();
    logic rv;
    rv = m_started && !m_have;
    check("ireq_valid", ireq_valid, rv);
    if (rv) check("ireq_addr", ireq_addr, m_pc);
    if (m_have) check("pc", pc, m_pc);
    check("raw_instr", raw_instr, m_word);
    check("ivalid", ivalid, m_have);
    check("instr_FETCH", 64'(instr_FETCH), (m_have && stall_F && !redirect_valid) ? 64'(INSTR_MAINTAIN) : 64'(INSTR_CONTINUE));
    check("Iwait", Iwait, rv && !iresp_data_ok);
`ifdef FETCH_CTRL_PERF_EN
    check("fetch_cnt", fetch_cnt, m_fc);
    check("stall_cnt", stall_cnt, m_sc);
`endif
  endtask

  task automatic drive(input logic ok, input logic [31:0] data, input logic stall,
                       input logic redir, input logic [63:0] rpc);
    @(negedge clk);
    iresp_data_ok  = ok;
    iresp_data     = data;
    stall_F        = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1 compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    iresp_data_ok  = 1'b0;
    redirect_valid = 1'b0;
    stall_F        = 1'b0;
    #1 model_reset();
    check("rst_ireq_valid", ireq_valid, 1'b0);
    check("rst_Iwait", Iwait, 1'b0);
    check("rst_ivalid", ivalid, 1'b0);
    check("rst_raw_instr", raw_instr, 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    drive(0, 0, 0, 0, 0);
    check("idle_noreq", ireq_valid, 1'b0);
    tick();
    drive(1, 32'h0000_0013, 0, 0, 0);
    check("first_addr", ireq_addr, 64'h8000_0000);
    tick();
    drive(0, 0, 0, 0, 0);
    check("first_valid", ivalid, 1'b1);
    check("first_word", raw_instr, 64'h13);
    tick();
    drive(1, 32'h0000_0093, 0, 0, 0);
    check("next_addr", ireq_addr, 64'h8000_0004);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0);
      check("stall_maintain", 64'(instr_FETCH), 64'(INSTR_MAINTAIN));
      check("stall_noreq", ireq_valid, 1'b0);
      check("stall_pc", pc, 64'h8000_0004);
      check("stall_word", raw_instr, 64'h93);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      check("wait_Iwait", Iwait, 1'b1);
      check("wait_addr", ireq_addr, 64'h8000_0008);
      tick();
    end
    drive(1, 32'hDEAD_BEEF, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("late_word", raw_instr, 64'hDEAD_BEEF);
    tick();
    drive(0, 0, 0, 1, 64'h8000_0100);
    tick();
    drive(0, 0, 0, 0, 0);
    check("drain_addr", ireq_addr, 64'h8000_000C);
    tick();
    drive(1, 32'hBAD0_BAD0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("drain_dropped", ivalid, 1'b0);
    check("drain_target", ireq_addr, 64'h8000_0100);
    tick();
    drive(1, 32'h1111_1111, 0, 1, 64'h8000_0200);
    tick();
    drive(0, 0, 0, 0, 0);
    check("coinc_dropped", ivalid, 1'b0);
    check("coinc_target", ireq_addr, 64'h8000_0200);
    tick();
    drive(1, 32'h5555_5555, 0, 0, 0);
    tick();
    drive(0, 0, 1, 1, 64'h8000_0303);
    check("redir_over_stall", 64'(instr_FETCH), 64'(INSTR_CONTINUE));
    tick();
    drive(0, 0, 0, 0, 0);
    check("stall_redir_addr", ireq_addr, 64'h8000_0300);
    tick();
    do_reset();
    drive(1, 32'h7777_7777, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("post_rst_addr", ireq_addr, 64'h8000_0000);
    check("post_rst_ignored", ivalid, 1'b0);
    tick();
    drive(1, 32'h2222_2222, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    drive(1, 32'h3333_3333, 0, 0, 0);
    check("wrap_top", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("wrap_zero", ireq_addr, 64'd0);
    tick();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else begin
        drive(1'($urandom_range(1)), $urandom, 1'($urandom_range(2) == 0),
              1'($urandom_range(9) == 0),
              $urandom_range(1) ? {32'hFFFF_FFFF, $urandom} : {$urandom, $urandom});
        tick();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 RESET_PC, 64'h8000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 ireq_valid  output  1  instruction-bus request valid.
REQ-005 ireq_addr  output  64  instruction-bus request address.
REQ-006 iresp_data_ok  input  1  response valid for the outstanding request.
REQ-007 iresp_data  input  32  returned instruction word.
REQ-008 stall_F  input  1  downstream hold of the fetch stage.
REQ-009 redirect_valid  input  1  control-flow redirect request.
REQ-010 redirect_pc  input  64  redirect target.
REQ-011 pc  output  64  PC of the presented instruction.
REQ-012 raw_instr  output  32  presented instruction word.
REQ-013 ivalid  output  1  presented instruction is valid.
REQ-014 instr_FETCH  output  instr_FETCH_t  INSTR_CONTINUE or INSTR_MAINTAIN.
REQ-015 Iwait  output  1  fetch is waiting on the instruction bus.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, DRAIN, VALID.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then enter REQ.
REQ-018 In REQ and DRAIN, ireq_valid SHALL be 1; ireq_addr SHALL stay stable until iresp_data_ok.
REQ-019 In REQ, on iresp_data_ok with no redirect that cycle, the FSM SHALL latch iresp_data and enter VALID.
REQ-020 In VALID, ivalid SHALL be 1, pc and raw_instr SHALL hold the latched values, and ireq_valid SHALL be 0.
REQ-021 In VALID with stall_F=1, the FSM SHALL stay in VALID and drive INSTR_MAINTAIN.
REQ-022 In VALID with stall_F=0, the FSM SHALL drive INSTR_CONTINUE, set pc_q<=pc_q+4 and enter REQ.
REQ-023 In every state except VALID, ivalid SHALL be 0 and instr_FETCH SHALL be INSTR_CONTINUE.
REQ-024 Redirect in VALID or IDLE: pc_q<=redirect_pc; next state REQ; this takes priority over stall_F.
REQ-025 Redirect in REQ with iresp_data_ok=1: the response SHALL be discarded; pc_q<=redirect_pc; next state REQ.
REQ-026 Redirect in REQ with iresp_data_ok=0: the target SHALL be saved and the FSM SHALL enter DRAIN, keeping the old address.
REQ-027 In DRAIN, on iresp_data_ok the response SHALL be discarded; pc_q<=saved target; next state REQ.
REQ-028 A redirect in DRAIN SHALL overwrite the saved target; if it coincides with iresp_data_ok, the new target SHALL be used.
REQ-029 Iwait SHALL equal ireq_valid & ~iresp_data_ok.
REQ-030 redirect_pc[1:0] SHALL be forced to 2'b00 on load; pc increments SHALL wrap modulo 2^64.
REQ-031 Best-case throughput SHALL be one instruction per two cycles when iresp_data_ok is returned in the request cycle.

Reset
REQ-032 Asserting resetn=0 SHALL immediately force state IDLE, pc_q=RESET_PC, the saved target to 0, raw_instr to 0, and ivalid, ireq_valid and Iwait to 0.
REQ-033 Reset mid-request SHALL abandon the transaction; a response arriving after release SHALL be ignored unless the FSM is in REQ.

Configuration
REQ-034 With FETCH_CTRL_PERF_EN defined, 64-bit counters fetch_cnt and stall_cnt SHALL be output.
REQ-035 Under FETCH_CTRL_PERF_EN, fetch_cnt SHALL increment on each VALID cycle with stall_F=0, and stall_cnt SHALL increment on each cycle Iwait=1.
REQ-036 Under FETCH_CTRL_PERF_EN, both counters SHALL reset to 0.
REQ-037 Without FETCH_CTRL_PERF_EN, neither the counters nor their ports SHALL exist, and behaviour SHALL be otherwise identical.

Structure
REQ-038 instr_FETCH_t SHALL come from package pipes, and u32/u64 from package common.
REQ-039 The FSM state enum and RESET_PC default SHALL be added to package pipes.
REQ-040 The block SHALL be a single module with no sub-modules; the counters SHALL be inline under the macro.

Verification
REQ-041 Reset release, data_ok in the same cycle as the request -> ireq_addr=0x8000_0000; ivalid=1 one cycle later; next ireq_addr=0x8000_0004.
REQ-042 data_ok delayed 3 cycles -> Iwait=1 for 3 cycles, ireq_addr stable, then ivalid=1 with the returned word.
REQ-043 stall_F=1 for 4 cycles in VALID -> INSTR_MAINTAIN for 4 cycles, pc/raw_instr unchanged, no request issued.
REQ-044 Redirect to 0x8000_0100 while waiting (no data_ok) -> old address held; stale word discarded (ivalid stays 0); next request at 0x8000_0100.
REQ-045 Redirect coincident with data_ok, and redirect coincident with stall_F in VALID -> response dropped / stall ignored; next request at the target.
REQ-046 resetn asserted while waiting -> ireq_valid=0 asynchronously; after release, the first request is at RESET_PC.
